config_read_initiator: RTL and testbench

Master side of the config read interface: accepts AXI-Lite read requests (AR/R channels) from the host shell and issues them as `read_config_i` transactions toward the config register fabric. Captures the responder's data and error flag and returns them as an AXI-Lite R beat. It handles exactly one outstanding read and applies back-pressure while busy. It sits between the AXI-Lite slave port and the config register decode tree.

---
 rtl/config_pkg.sv | 22 ++
 rtl/config_read_initiator_if.sv | 23 ++
 rtl/config_timeout_counter.sv | 41 ++++
 rtl/config_read_initiator.sv | 188 ++++++++++++++++++
 tb/tb_config_read_initiator.sv | 373 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/config_pkg.sv
// Shared types and constants for the config read path: AXI-Lite widths,
// response codes and the read initiator state encoding.
package config_pkg;

    localparam int unsigned AXIL_ADDR_BITS = 32;
    localparam int unsigned AXIL_DATA_BITS = 32;

    localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        REQ       = 2'b01,
        WAIT_RESP = 2'b10,
        RESP      = 2'b11
    } cfg_rd_state_t;

    function automatic logic [1:0] axil_resp_from_error(input logic err);
        return err ? AXIL_RESP_SLVERR : AXIL_RESP_OKAY;
    endfunction

endpackage

// File: rtl/config_read_initiator_if.sv
// read_config_i: request/response handshake between a config read master
// and the config register fabric (m = initiator, s = responder).
interface read_config_i
    import config_pkg::*;
();
    logic                      read_valid;
    logic [AXIL_ADDR_BITS-1:0] read_addr;
    logic                      read_ready;
    logic                      resp_valid;
    logic [AXIL_DATA_BITS-1:0] resp_data;
    logic                      resp_error;
    logic                      resp_ready;

    modport m (
        output read_valid, read_addr, resp_ready,
        input  read_ready, resp_valid, resp_data, resp_error
    );

    modport s (
        input  read_valid, read_addr, resp_ready,
        output read_ready, resp_valid, resp_data, resp_error
    );
endinterface

// File: rtl/config_timeout_counter.sv
// Phase counter for the read initiator: clears on phase entry, counts cycles
// spent in the phase and flags expiry once LIMIT cycles have elapsed.
module config_timeout_counter #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired
);

    localparam int unsigned CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign expired = (count_q == CW'(LIMIT - 1));

    // Next count: clear wins, saturate once expired.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = {CW{1'b0}};
        end else if (enable_i && !expired) begin
            count_d = count_q + CW'(1'b1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= {CW{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/config_read_initiator.sv
// AXI-Lite AR/R to read_config_i bridge, one outstanding read. Optional
// per-phase abort with stale-response discard under CONFIG_READ_TIMEOUT_EN.
module config_read_initiator
    import config_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [AXIL_ADDR_BITS-1:0] s_araddr,
    input  logic                      s_arvalid,
    output logic                      s_arready,
    output logic [AXIL_DATA_BITS-1:0] s_rdata,
    output logic [1:0]                s_rresp,
    output logic                      s_rvalid,
    input  logic                      s_rready,
    read_config_i.m                   conf
);

    cfg_rd_state_t             state_q, state_d;
    logic                      arready_q, arready_d;
    logic                      read_valid_q, read_valid_d;
    logic [AXIL_ADDR_BITS-1:0] read_addr_q, read_addr_d;
    logic                      resp_ready_q, resp_ready_d;
    logic                      rvalid_q, rvalid_d;
    logic [AXIL_DATA_BITS-1:0] rdata_q, rdata_d;
    logic [1:0]                rresp_q, rresp_d;

    assign s_arready       = arready_q;
    assign s_rvalid        = rvalid_q;
    assign s_rdata         = rdata_q;
    assign s_rresp         = rresp_q;
    assign conf.read_valid = read_valid_q;
    assign conf.read_addr  = read_addr_q;
    assign conf.resp_ready = resp_ready_q;

`ifdef CONFIG_READ_TIMEOUT_EN
    logic stale_q, stale_d;
    logic timeout_s;
    logic phase_clear_s;
    logic phase_en_s;

    assign phase_en_s    = (state_q == REQ) || (state_q == WAIT_RESP);
    assign phase_clear_s = (state_d != state_q) &&
                           ((state_d == REQ) || (state_d == WAIT_RESP));

    config_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (phase_clear_s),
        .enable_i (phase_en_s),
        .expired  (timeout_s)
    );
`endif

    // Next-state and next-output logic for the read FSM.
    always_comb begin
        state_d      = state_q;
        read_valid_d = read_valid_q;
        read_addr_d  = read_addr_q;
        resp_ready_d = resp_ready_q;
        rvalid_d     = rvalid_q;
        rdata_d      = rdata_q;
        rresp_d      = rresp_q;
`ifdef CONFIG_READ_TIMEOUT_EN
        stale_d      = stale_q;
`endif
        case (state_q)
            IDLE: begin
                if (s_arvalid && arready_q) begin
                    read_addr_d  = s_araddr;
                    read_valid_d = 1'b1;
                    state_d      = REQ;
                end
`ifdef CONFIG_READ_TIMEOUT_EN
                // A late response to an aborted read is swallowed here.
                else if (stale_q && resp_ready_q && conf.resp_valid) begin
                    stale_d      = 1'b0;
                    resp_ready_d = 1'b0;
                end else begin
                    resp_ready_d = stale_q;
                end
`else
                else begin
                    resp_ready_d = 1'b0;
                end
`endif
            end
            REQ: begin
                if (conf.read_ready) begin
                    read_valid_d = 1'b0;
                    resp_ready_d = 1'b1;
                    state_d      = WAIT_RESP;
                end
`ifdef CONFIG_READ_TIMEOUT_EN
                else if (timeout_s) begin
                    read_valid_d = 1'b0;
                    rdata_d      = {AXIL_DATA_BITS{1'b0}};
                    rresp_d      = AXIL_RESP_SLVERR;
                    rvalid_d     = 1'b1;
                    state_d      = RESP;
                end
`endif
                else begin
                    state_d = REQ;
                end
            end
            WAIT_RESP: begin
                if (conf.resp_valid) begin
                    rdata_d      = conf.resp_data;
                    rresp_d      = axil_resp_from_error(conf.resp_error);
                    rvalid_d     = 1'b1;
                    resp_ready_d = 1'b0;
                    state_d      = RESP;
                end
`ifdef CONFIG_READ_TIMEOUT_EN
                else if (timeout_s) begin
                    rdata_d      = {AXIL_DATA_BITS{1'b0}};
                    rresp_d      = AXIL_RESP_SLVERR;
                    rvalid_d     = 1'b1;
                    resp_ready_d = 1'b0;
                    stale_d      = 1'b1;
                    state_d      = RESP;
                end
`endif
                else begin
                    state_d = WAIT_RESP;
                end
            end
            RESP: begin
                if (s_rready) begin
                    rvalid_d = 1'b0;
                    state_d  = IDLE;
`ifdef CONFIG_READ_TIMEOUT_EN
                    resp_ready_d = stale_q;
`endif
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
`ifdef CONFIG_READ_TIMEOUT_EN
        arready_d = (state_d == IDLE) && !stale_d;
`else
        arready_d = (state_d == IDLE);
`endif
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            arready_q    <= 1'b0;
            read_valid_q <= 1'b0;
            read_addr_q  <= {AXIL_ADDR_BITS{1'b0}};
            resp_ready_q <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= {AXIL_DATA_BITS{1'b0}};
            rresp_q      <= AXIL_RESP_OKAY;
        end else begin
            state_q      <= state_d;
            arready_q    <= arready_d;
            read_valid_q <= read_valid_d;
            read_addr_q  <= read_addr_d;
            resp_ready_q <= resp_ready_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            rresp_q      <= rresp_d;
        end
    end

`ifdef CONFIG_READ_TIMEOUT_EN
    // Stale-response flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stale_q <= 1'b0;
        end else begin
            stale_q <= stale_d;
        end
    end
`endif

endmodule

// File: tb/tb_config_read_initiator.sv
// Scoreboard bench for config_read_initiator: directed AR reads against a
// scripted responder; a negedge monitor checks every R beat against the queue.
`timescale 1ns/1ps
module tb_config_read_initiator;
    import config_pkg::*;

    localparam int unsigned TO_CYC = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_araddr;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready;

    read_config_i conf_if ();

    config_read_initiator #(
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_araddr  (s_araddr),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .conf      (conf_if)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int rise_cyc = -1;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;
    exp_t sb_q[$];

    // Responder controls
    int rr_low    = 0;
    bit drop_resp = 1'b0;
    bit late_go   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic void rsp_lookup(input logic [31:0] a, output logic [31:0] d, output logic e);
        case (a)
            32'h0000_0010: begin d = 32'hCAFE_0001; e = 1'b0; end
            32'h0000_0014: begin d = 32'hDEAD_0014; e = 1'b1; end
            32'h0000_0000: begin d = 32'h1111_0000; e = 1'b0; end
            32'h0000_0004: begin d = 32'h2222_0004; e = 1'b0; end
            32'h0000_0020: begin d = 32'h5A5A_0020; e = 1'b0; end
            default:       begin d = 32'hBAD0_0000; e = 1'b0; end
        endcase
    endfunction

    // Responder: read_ready optionally held low rr_low cycles, resp one cycle after accept.
    initial begin : responder
        int phase;
        int low_cnt;
        logic [31:0] addr;
        logic [31:0] d;
        logic        e;
        phase = 0;
        low_cnt = 0;
        conf_if.read_ready = 1'b1;
        conf_if.resp_valid = 1'b0;
        conf_if.resp_data  = 32'h0;
        conf_if.resp_error = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                phase = 0;
                low_cnt = 0;
                conf_if.resp_valid = 1'b0;
                conf_if.read_ready = (rr_low == 0);
            end else begin
                case (phase)
                    0: begin
                        if (conf_if.read_valid) begin
                            if (low_cnt < rr_low) begin
                                conf_if.read_ready = 1'b0;
                                low_cnt++;
                            end else begin
                                conf_if.read_ready = 1'b1;
                                addr = conf_if.read_addr;
                                low_cnt = 0;
                                phase = 1;
                            end
                        end else begin
                            conf_if.read_ready = (rr_low == 0);
                        end
                    end
                    1: begin
                        if (drop_resp) begin
                            phase = 4;
                        end else begin
                            rsp_lookup(addr, d, e);
                            conf_if.resp_data  = d;
                            conf_if.resp_error = e;
                            conf_if.resp_valid = 1'b1;
                            phase = conf_if.resp_ready ? 3 : 2;
                        end
                    end
                    2: begin
                        if (conf_if.resp_ready) phase = 3;
                    end
                    3: begin
                        conf_if.resp_valid = 1'b0;
                        phase = 0;
                    end
                    4: begin
                        if (late_go) begin
                            conf_if.resp_data  = 32'hDEAD_BEEF;
                            conf_if.resp_error = 1'b0;
                            conf_if.resp_valid = 1'b1;
                            phase = conf_if.resp_ready ? 3 : 2;
                        end
                    end
                    default: phase = 0;
                endcase
            end
        end
    end

    // Monitor: pop and compare on every R handshake.
    initial begin : monitor
        bit   rv_prev;
        exp_t e;
        rv_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && s_rvalid && !rv_prev) rise_cyc = cyc;
            rv_prev = s_rvalid && !rst;
            if (!rst && s_rvalid && s_rready) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_r: got beat data 0x%08h resp %0d, expected no beat", s_rdata, s_rresp);
                end else begin
                    e = sb_q.pop_front();
                    check("r_data", s_rdata, e.data);
                    check("r_resp", {30'b0, s_rresp}, {30'b0, e.resp});
                end
            end
        end
    end

    task automatic push_exp(input logic [31:0] d, input logic [1:0] r);
        exp_t e;
        e.data = d;
        e.resp = r;
        sb_q.push_back(e);
    endtask

    task automatic wait_ar(input string name, output int hs_cyc);
        bit got;
        got = 1'b0;
        hs_cyc = -1;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (s_arready) begin
                hs_cyc = cyc;
                got = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!got) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: got no AR handshake within 60 cycles, expected one", name);
        end
    endtask

    task automatic wait_rise(input string name);
        for (int i = 0; i < 60 && rise_cyc == -1; i++) begin
            @(posedge clk);
            #1;
        end
        if (rise_cyc == -1) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: got no s_rvalid within 60 cycles, expected one", name);
        end
    endtask

    task automatic drain(input string name);
        int i;
        for (i = 0; i < 100 && (sb_q.size() != 0 || s_rvalid); i++) begin
            @(posedge clk);
            #1;
        end
        if (i >= 100) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: got %0d beats pending after 100 cycles, expected 0", name, sb_q.size());
        end
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int h1;
        int h2;
        s_arvalid = 1'b0;
        s_araddr  = 32'h0;
        s_rready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_arready", {31'b0, s_arready}, 32'd0);
        check("rst_rvalid", {31'b0, s_rvalid}, 32'd0);
        check("rst_rdata", s_rdata, 32'h0);
        check("rst_rresp", {30'b0, s_rresp}, 32'd0);
        check("rst_read_valid", {31'b0, conf_if.read_valid}, 32'd0);
        check("rst_read_addr", conf_if.read_addr, 32'h0);
        check("rst_resp_ready", {31'b0, conf_if.resp_ready}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("arready_after_rst", {31'b0, s_arready}, 32'd1);

        // Best-case read of 0x10
        rise_cyc = -1;
        push_exp(32'hCAFE_0001, AXIL_RESP_OKAY);
        s_araddr = 32'h10;
        s_arvalid = 1'b1;
        wait_ar("t1_ar", h1);
        s_arvalid = 1'b0;
        wait_rise("t1_rise");
        check("t1_latency", rise_cyc - h1, 32'd3);
        drain("t1_drain");

        // Error response
        push_exp(32'hDEAD_0014, AXIL_RESP_SLVERR);
        s_araddr = 32'h14;
        s_arvalid = 1'b1;
        wait_ar("t2_ar", h1);
        s_arvalid = 1'b0;
        drain("t2_drain");

        // Stalls on both sides
        rr_low = 5;
        s_rready = 1'b0;
        rise_cyc = -1;
        push_exp(32'h5A5A_0020, AXIL_RESP_OKAY);
        s_araddr = 32'h20;
        s_arvalid = 1'b1;
        wait_ar("t3_ar", h1);
        s_arvalid = 1'b0;
        s_araddr = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_read_valid", {31'b0, conf_if.read_valid}, 32'd1);
            check("t3_read_addr", conf_if.read_addr, 32'h20);
            check("t3_arready_req", {31'b0, s_arready}, 32'd0);
        end
        wait_rise("t3_rise");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t3_rvalid_hold", {31'b0, s_rvalid}, 32'd1);
            check("t3_rdata_hold", s_rdata, 32'h5A5A_0020);
            check("t3_rresp_hold", {30'b0, s_rresp}, 32'd0);
            check("t3_arready_resp", {31'b0, s_arready}, 32'd0);
        end
        @(posedge clk);
        #1;
        s_rready = 1'b1;
        rr_low = 0;
        drain("t3_drain");

        // Back-to-back ARs with s_arvalid held
        push_exp(32'h1111_0000, AXIL_RESP_OKAY);
        push_exp(32'h2222_0004, AXIL_RESP_OKAY);
        s_araddr = 32'h0;
        s_arvalid = 1'b1;
        wait_ar("t4_ar0", h1);
        s_araddr = 32'h4;
        wait_ar("t4_ar1", h2);
        s_arvalid = 1'b0;
        check("t4_gap", h2 - h1, 32'd4);
        drain("t4_drain");

`ifdef CONFIG_READ_TIMEOUT_EN
        // Responder never answers: abort, then discard the late response
        drop_resp = 1'b1;
        rise_cyc = -1;
        push_exp(32'h0, AXIL_RESP_SLVERR);
        s_araddr = 32'h30;
        s_arvalid = 1'b1;
        wait_ar("t5_ar", h1);
        s_arvalid = 1'b0;
        wait_rise("t5_rise");
        check("t5_latency", rise_cyc - h1, 32'd10);
        drain("t5_drain");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_stale_arready", {31'b0, s_arready}, 32'd0);
            check("t5_stale_resp_ready", {31'b0, conf_if.resp_ready}, 32'd1);
        end
        late_go = 1'b1;
        push_exp(32'hCAFE_0001, AXIL_RESP_OKAY);
        s_araddr = 32'h10;
        s_arvalid = 1'b1;
        wait_ar("t5_resume_ar", h2);
        s_arvalid = 1'b0;
        drop_resp = 1'b0;
        late_go = 1'b0;
        drain("t5_drain2");
`endif

        // Reset while waiting for the response
        drop_resp = 1'b1;
        s_araddr = 32'h14;
        s_arvalid = 1'b1;
        wait_ar("t6_ar", h1);
        s_arvalid = 1'b0;
        for (int i = 0; i < 20 && !conf_if.resp_ready; i++) @(negedge clk);
        check("t6_in_wait_resp", {31'b0, conf_if.resp_ready}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_arready", {31'b0, s_arready}, 32'd0);
        check("t6_rvalid", {31'b0, s_rvalid}, 32'd0);
        check("t6_rdata", s_rdata, 32'h0);
        check("t6_rresp", {30'b0, s_rresp}, 32'd0);
        check("t6_read_valid", {31'b0, conf_if.read_valid}, 32'd0);
        check("t6_read_addr", conf_if.read_addr, 32'h0);
        check("t6_resp_ready", {31'b0, conf_if.resp_ready}, 32'd0);
        drop_resp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("t6_arready_after", {31'b0, s_arready}, 32'd1);
        push_exp(32'h2222_0004, AXIL_RESP_OKAY);
        s_araddr = 32'h4;
        s_arvalid = 1'b1;
        wait_ar("t6_ar2", h2);
        s_arvalid = 1'b0;
        drain("t6_drain");

        repeat (5) @(posedge clk);
        #1;
        check("sb_empty", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
